jram_arbiter: RTL

//  Two-port access controller for the 256x8 RAM block (MAR plus 16x16 register array).

---
 rtl/jram_arbiter_if.sv | 47 ++++
 rtl/jram_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/jram_arbiter_if.sv
// Requester A/B handshake, RAM strobe/bus and busy signals for jram_arbiter.
// slave: arbiter side; master: requesters plus RAM side.
interface jram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          a_req;
  logic          a_wr;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_wr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;

  logic [AW-1:0] ram_bas;
  logic          ram_wsa;
  logic [DW-1:0] ram_bis;
  logic          ram_ws;
  logic          ram_we;
  logic [DW-1:0] ram_bos;

  logic          busy;

  modport slave (
    input  a_req, a_wr, a_addr, a_wdata,
    input  b_req, b_wr, b_addr, b_wdata,
    input  ram_bos,
    output a_ack, a_rdata, b_ack, b_rdata,
    output ram_bas, ram_wsa, ram_bis, ram_ws, ram_we,
    output busy
  );

  modport master (
    output a_req, a_wr, a_addr, a_wdata,
    output b_req, b_wr, b_addr, b_wdata,
    output ram_bos,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  ram_bas, ram_wsa, ram_bis, ram_ws, ram_we,
    input  busy
  );
endinterface

// File: rtl/jram_arbiter.sv
// Two-port access controller for the 256x8 RAM: arbitrates A/B, sequences wsa -> ws/we, acks.
// JRAM_ARB_RR_EN defined: round-robin on ties; undefined: fixed priority, A wins ties.
module jram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  jram_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_gnt_b;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic          r_a_ack;
  logic          r_b_ack;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;
  logic [AW-1:0] r_bas;
  logic          r_wsa;
  logic [DW-1:0] r_bis;
  logic          r_ws;
  logic          r_we;
  logic          r_busy;

  logic          w_any_req;
  logic          w_pick_b;

  assign w_any_req = bus.a_req | bus.b_req;

`ifdef JRAM_ARB_RR_EN
  logic r_last_b;

  // On a tie, grant whichever port did not win the previous transaction.
  assign w_pick_b = bus.b_req & (~bus.a_req | ~r_last_b);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_b <= 1'b1;
    end else if (r_state == S_DONE) begin
      r_last_b <= r_gnt_b;
    end
  end
`else
  assign w_pick_b = bus.b_req & ~bus.a_req;
`endif

  // Strobes, buses and acks are single-cycle: cleared every cycle unless the
  // transition into the next state sets them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_gnt_b   <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_bas     <= '0;
      r_wsa     <= 1'b0;
      r_bis     <= '0;
      r_ws      <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_bas   <= '0;
      r_wsa   <= 1'b0;
      r_bis   <= '0;
      r_ws    <= 1'b0;
      r_we    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_b <= w_pick_b;
            r_wr    <= w_pick_b ? bus.b_wr    : bus.a_wr;
            r_addr  <= w_pick_b ? bus.b_addr  : bus.a_addr;
            r_wdata <= w_pick_b ? bus.b_wdata : bus.a_wdata;
            r_bas   <= w_pick_b ? bus.b_addr  : bus.a_addr;
            r_wsa   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (r_wr) begin
            r_bis <= r_wdata;
            r_ws  <= 1'b1;
          end else begin
            r_we  <= 1'b1;
          end
          r_state <= S_ACCESS;
        end

        S_ACCESS: begin
          if (!r_wr) begin
            if (r_gnt_b) begin
              r_b_rdata <= bus.ram_bos;
            end else begin
              r_a_rdata <= bus.ram_bos;
            end
          end
          r_a_ack <= ~r_gnt_b;
          r_b_ack <= r_gnt_b;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.a_ack   = r_a_ack;
  assign bus.b_ack   = r_b_ack;
  assign bus.a_rdata = r_a_rdata;
  assign bus.b_rdata = r_b_rdata;
  assign bus.ram_bas = r_bas;
  assign bus.ram_wsa = r_wsa;
  assign bus.ram_bis = r_bis;
  assign bus.ram_ws  = r_ws;
  assign bus.ram_we  = r_we;
  assign bus.busy    = r_busy;

endmodule
